// File: rtl/isqrt_seq_if.sv
// -----------------------------------------------------------------------------
// isqrt_seq_if
//   Handshake bundle for the sequential integer square-root unit.
//   Input side : in_valid / in_ready / in_data (radicand, IN_W bits)
//   Output side: out_valid / out_ready / out_root (OUT_W bits)
//                plus out_rem (OUT_W+1 bits) and out_exact when the
//                ISQRT_REMAINDER_EN macro is defined.
//   Modports:
//     slave  - the square-root unit (consumes radicands, produces roots)
//     master - whatever feeds radicands and collects roots
// -----------------------------------------------------------------------------
interface isqrt_seq_if #(
    parameter int IN_W = 6
);
    localparam int OUT_W = IN_W / 2;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_root;
`ifdef ISQRT_REMAINDER_EN
    logic [OUT_W:0]   out_rem;
    logic             out_exact;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_root, out_rem, out_exact
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_root, out_rem, out_exact
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_root
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_root
    );
`endif
endinterface

// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq
//   Sequential integer square root: out_root = floor(sqrt(in_data)).
//   Restoring digit-by-digit algorithm, one root bit per clock, so a result
//   appears OUT_W cycles after the accept cycle.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous reset, active-high
//     bus  - isqrt_seq_if.slave: radicand valid/ready in, root valid/ready out
//
//   Parameters:
//     IN_W  - radicand width, even and >= 2
//     OUT_W - IN_W/2, derived (localparam)
//
//   Optional feature macro: ISQRT_REMAINDER_EN
//     defined   -> out_rem (in_data - root^2) and out_exact (out_rem == 0)
//                  are exported on the interface
//     undefined -> remainder kept internally only; root behaviour unchanged
// -----------------------------------------------------------------------------
module isqrt_seq #(
    parameter int IN_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    isqrt_seq_if.slave   bus
);
    localparam int OUT_W = IN_W / 2;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    generate
        if ((IN_W % 2) != 0 || IN_W < 2) begin : g_bad_width
            $error("isqrt_seq: IN_W must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q;
    logic [IN_W-1:0]    rad_q;      // unconsumed radicand bits, MSB-aligned
    logic [OUT_W-1:0]   root_q;     // partial root
    logic [OUT_W:0]     rem_q;      // partial remainder, <= 2*root
    logic [CNT_W-1:0]   cnt_q;      // remaining CALC steps minus one
    logic [OUT_W-1:0]   out_root_q;
`ifdef ISQRT_REMAINDER_EN
    logic [OUT_W:0]     out_rem_q;
    logic               out_exact_q;
`endif

    // One restoring step, computed combinationally from the current state.
    logic [OUT_W+1:0]   rem_shift;
    logic [OUT_W+1:0]   trial;
    logic [OUT_W+1:0]   diff;
    logic               take;
    logic [OUT_W:0]     rem_d;
    logic [OUT_W-1:0]   root_d;
    logic [IN_W-1:0]    rad_d;

    // NOTE: combinational logic uses blocking '=', registers use '<=' only;
    // mixing them in one block gives simulation/synthesis mismatches.
    always_comb begin
        // rem_q's MSB is zero whenever the shift would push it out, since the
        // pre-shift remainder is bounded by 2*root of a shorter partial root.
        rem_shift = (OUT_W+2)'({rem_q, rad_q[IN_W-1 -: 2]});
        trial     = {root_q, 2'b01};
        take      = (rem_shift >= trial);
        diff      = rem_shift - trial;
        rem_d     = (OUT_W+1)'(take ? diff : rem_shift);
        root_d    = (root_q << 1) | OUT_W'(take);
        rad_d     = rad_q << 2;
    end

    // NOTE: reset is synchronous -- it is only seen at a rising clk edge and
    // sits inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rad_q       <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_root_q  <= '0;
`ifdef ISQRT_REMAINDER_EN
            out_rem_q   <= '0;
            out_exact_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        rad_q   <= bus.in_data;
                        root_q  <= '0;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(OUT_W - 1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    root_q <= root_d;
                    rem_q  <= rem_d;
                    rad_q  <= rad_d;
                    if (cnt_q == '0) begin
                        // Result registers only move on the final step, so
                        // they hold the last answer through DONE and IDLE.
                        out_root_q  <= root_d;
`ifdef ISQRT_REMAINDER_EN
                        out_rem_q   <= rem_d;
                        out_exact_q <= (rem_d == '0);
`endif
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready drops in the reset cycle itself so nothing is accepted then.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_root  = out_root_q;
`ifdef ISQRT_REMAINDER_EN
    assign bus.out_rem   = out_rem_q;
    assign bus.out_exact = out_exact_q;
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq
//   Directed bench for isqrt_seq: one IN_W=6 and one IN_W=8 instance sharing
//   clk/rst. Inputs are driven and outputs sampled 1 time unit after the
//   rising edge. Remainder/exact checks are compiled in only when
//   ISQRT_REMAINDER_EN is defined.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    isqrt_seq_if #(.IN_W(6)) b6 ();
    isqrt_seq_if #(.IN_W(8)) b8 ();

    isqrt_seq #(.IN_W(6)) dut6 (.clk(clk), .rst(rst), .bus(b6));
    isqrt_seq #(.IN_W(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Send one radicand to the 6-bit unit and collect its result.
    // busy_ok is 1 if in_ready stayed low from accept up to the handshake.
    task automatic send6(input int x, input bit keep_ready,
                         output int root, output int rem, output int ex,
                         output int lat, output int busy_ok);
        int w = 0;
        while (!b6.in_ready && w < 20) begin
            tick();
            w++;
        end
        b6.in_data  = x[5:0];
        b6.in_valid = 1'b1;
        tick();
        b6.in_valid = 1'b0;
        lat     = 0;
        busy_ok = 1;
        while (!b6.out_valid && lat < 20) begin
            if (b6.in_ready) busy_ok = 0;
            tick();
            lat++;
        end
        if (b6.in_ready) busy_ok = 0;
        root = int'(b6.out_root);
`ifdef ISQRT_REMAINDER_EN
        rem = int'(b6.out_rem);
        ex  = int'(b6.out_exact);
`else
        rem = 0;
        ex  = 0;
`endif
        b6.out_ready = 1'b1;
        tick();
        if (!keep_ready) b6.out_ready = 1'b0;
    endtask

    task automatic send8(input int x, output int root, output int rem, output int lat);
        int w = 0;
        while (!b8.in_ready && w < 20) begin
            tick();
            w++;
        end
        b8.in_data  = x[7:0];
        b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        lat = 0;
        while (!b8.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        root = int'(b8.out_root);
`ifdef ISQRT_REMAINDER_EN
        rem = int'(b8.out_rem);
`else
        rem = 0;
`endif
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
    endtask

    initial begin
        int root, rem, ex, lat, busy_ok;
        int ok;

        rst          = 1'b1;
        b6.in_valid  = 1'b0;
        b6.in_data   = '0;
        b6.out_ready = 1'b0;
        b8.in_valid  = 1'b0;
        b8.in_data   = '0;
        b8.out_ready = 1'b0;
        tick();
        tick();
        check("in_ready_during_rst", b6.in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", b6.out_valid, 0);
        check("rst_out_root", b6.out_root, 0);
        check("rst_in_ready", b6.in_ready, 1);
        check("rst_out_valid8", b8.out_valid, 0);

        // 49 -> 7, rem 0, exact
        send6(49, 1'b0, root, rem, ex, lat, busy_ok);
        check("sq49_latency", lat, 3);
        check("sq49_root", root, 7);
`ifdef ISQRT_REMAINDER_EN
        check("sq49_rem", rem, 0);
        check("sq49_exact", ex, 1);
`endif
        check("sq49_idle_after", b6.in_ready, 1);

        // Back-to-back 0, 63, 48 with out_ready held high
        b6.out_ready = 1'b1;
        send6(0, 1'b1, root, rem, ex, lat, busy_ok);
        check("b2b0_root", root, 0);
        check("b2b0_busy", busy_ok, 1);
        check("b2b0_latency", lat, 3);
`ifdef ISQRT_REMAINDER_EN
        check("b2b0_rem", rem, 0);
`endif
        check("b2b0_ready_after", b6.in_ready, 1);
        send6(63, 1'b1, root, rem, ex, lat, busy_ok);
        check("b2b63_root", root, 7);
        check("b2b63_busy", busy_ok, 1);
`ifdef ISQRT_REMAINDER_EN
        check("b2b63_rem", rem, 14);
        check("b2b63_exact", ex, 0);
`endif
        send6(48, 1'b0, root, rem, ex, lat, busy_ok);
        check("b2b48_root", root, 6);
        check("b2b48_busy", busy_ok, 1);
`ifdef ISQRT_REMAINDER_EN
        check("b2b48_rem", rem, 12);
`endif

        // Backpressure: 25 -> 5 held while out_ready low
        b6.in_data  = 6'd25;
        b6.in_valid = 1'b1;
        tick();
        b6.in_valid = 1'b0;
        lat = 0;
        while (!b6.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 3);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            b6.in_valid = i[0];
            b6.in_data  = 6'd9;
            if (!b6.out_valid || b6.out_root != 3'd5 || b6.in_ready) ok = 0;
            tick();
        end
        b6.in_valid = 1'b0;
        check("bp_held", ok, 1);
        check("bp_root", b6.out_root, 5);
        b6.out_ready = 1'b1;
        tick();
        b6.out_ready = 1'b0;
        check("bp_idle_ready", b6.in_ready, 1);
        check("bp_idle_valid", b6.out_valid, 0);
        tick();
        tick();
        tick();
        tick();
        check("bp_no_accept", b6.out_valid, 0);
        check("bp_root_hold", b6.out_root, 5);

        // Reset one cycle into CALC discards the operation
        b6.in_data  = 6'd49;
        b6.in_valid = 1'b1;
        tick();
        b6.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid", b6.out_valid, 0);
        check("midrst_root", b6.out_root, 0);
        check("midrst_ready", b6.in_ready, 1);
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b6.out_valid) ok = 0;
        end
        check("midrst_no_output", ok, 1);
        send6(36, 1'b0, root, rem, ex, lat, busy_ok);
        check("after_rst36_root", root, 6);

        // 8-bit instance
        send8(255, root, rem, lat);
        check("w8_255_latency", lat, 4);
        check("w8_255_root", root, 15);
`ifdef ISQRT_REMAINDER_EN
        check("w8_255_rem", rem, 30);
`endif
        send8(1, root, rem, lat);
        check("w8_1_root", root, 1);
`ifdef ISQRT_REMAINDER_EN
        check("w8_1_rem", rem, 0);
`endif

        // Sweep all 6-bit radicands against a squaring model
        for (int x = 0; x < 64; x++) begin
            int r = 0;
            while ((r + 1) * (r + 1) <= x) r++;
            send6(x, 1'b0, root, rem, ex, lat, busy_ok);
            check($sformatf("sweep_root_%0d", x), root, r);
            check($sformatf("sweep_bound_%0d", x),
                  ((root * root <= x) && (x < (root + 1) * (root + 1))) ? 1 : 0, 1);
`ifdef ISQRT_REMAINDER_EN
            check($sformatf("sweep_rem_%0d", x), rem, x - r * r);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
